ones_generator: RTL and testbench

//   Inverse of the ones-counter datapath: takes a count N and serially builds a WIDTH-bit

---
 rtl/ones_generator.sv | 144 ++++++++++++++
 tb/tb_ones_generator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_generator.sv
// -----------------------------------------------------------------------------
// ones_generator
//
// Serially builds a WIDTH-bit thermometer word holding exactly N ones, one bit
// per clock. This is the inverse of the ones-counter datapath: a word built
// here, fed back into the ones counter, must count back to N.
//
// A 4-state controller (IDLE -> LOAD -> FILL -> DONE -> IDLE) sequences a
// shift register (r_word) and a down-counter (r_cnt).
//
// Parameters
//   WIDTH      output word width (>= 2)
//   CW         count width, 2**CW > WIDTH
//   MSB_FIRST  0: ones packed at the LSBs, 1: ones packed at the MSBs
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high
//   start      in   1      request, sampled only in IDLE
//   count_in   in   CW     requested number of ones, sampled in LOAD
//   busy       out  1      high in LOAD, FILL and DONE
//   done       out  1      one-cycle pulse, high only in DONE
//   ovf        out  1      last request asked for more than WIDTH ones
//   word_out   out  WIDTH  shift register contents
// -----------------------------------------------------------------------------
module ones_generator #(
  parameter int WIDTH     = 16,
  parameter int CW        = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] count_in,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [WIDTH-1:0] word_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Largest count the word can hold; requests above it saturate here.
  localparam logic [CW-1:0] W_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Shift one more '1' into the word from the configured end.
  function automatic logic [WIDTH-1:0] shift_in_one(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {1'b1, w[WIDTH-1:1]};
    end else begin
      r = {w[WIDTH-2:0], 1'b1};
    end
    return r;
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             w_sat;
  logic             w_cnt_zero;

  assign w_sat      = (count_in > W_MAX);
  assign w_cnt_zero = (r_cnt == {CW{1'b0}});

  // Next-state logic of the controller.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: w_next_state = S_FILL;
      S_FILL: begin
        // Leave FILL only once every requested bit has been shifted in.
        if (w_cnt_zero) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: shift register, down-counter and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_word <= {WIDTH{1'b0}};
          r_cnt  <= w_sat ? W_MAX : count_in;
          r_ovf  <= w_sat;
        end
        S_FILL: begin
          // Decrement is gated by a non-zero count, so the counter never wraps.
          if (!w_cnt_zero) begin
            r_word <= shift_in_one(r_word);
            r_cnt  <= r_cnt - CNT_ONE;
          end else begin
            r_word <= r_word;
            r_cnt  <= r_cnt;
          end
        end
        default: begin
          // IDLE and DONE hold the last result so it stays visible.
          r_word <= r_word;
          r_cnt  <= r_cnt;
          r_ovf  <= r_ovf;
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign ovf      = r_ovf;
  assign word_out = r_word;

endmodule

// File: tb/tb_ones_generator.sv
module tb_ones_generator;

  localparam int WIDTH = 16;
  localparam int CW    = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              start_m;
  logic [CW-1:0]     count_in;
  logic              busy, done, ovf;
  logic              busy_m, done_m, ovf_m;
  logic [WIDTH-1:0]  word_out, word_m;

  always #5 clk = ~clk;

  ones_generator #(.WIDTH(WIDTH), .CW(CW), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .count_in(count_in),
    .busy(busy), .done(done), .ovf(ovf), .word_out(word_out)
  );

  ones_generator #(.WIDTH(WIDTH), .CW(CW), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .start(start_m), .count_in(count_in),
    .busy(busy_m), .done(done_m), .ovf(ovf_m), .word_out(word_m)
  );

  typedef struct packed {
    logic [15:0] word;
    logic        ovf;
    logic [4:0]  ones;
  } exp_t;

  exp_t q_l[$];
  exp_t q_m[$];
  exp_t e_l, e_m;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Thermometer word with min(n,16) ones, optionally packed at the MSBs.
  function automatic exp_t make_exp(input logic [4:0] n, input bit msb);
    exp_t        e;
    int          ns;
    logic [31:0] w;
    ns = (n > 5'd16) ? 16 : int'(n);
    w  = (32'd1 << ns) - 32'd1;
    e.word = w[15:0];
    if (msb) begin
      for (int i = 0; i < 16; i++) e.word[i] = w[15-i];
    end
    e.ovf  = (n > 5'd16);
    e.ones = 5'(ns);
    return e;
  endfunction

  // Reference ones counter used for the loopback check.
  function automatic int popcount(input logic [15:0] w);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) c += int'(w[i]);
    return c;
  endfunction

  // Scoreboard: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (q_l.size() == 0) begin
        check_val("unexpected_done", 32'(done), 32'd0);
      end else begin
        e_l = q_l.pop_front();
        check_val("word", 32'(word_out), 32'(e_l.word));
        check_val("ovf", 32'(ovf), 32'(e_l.ovf));
        check_val("loopback", 32'(popcount(word_out)), 32'(e_l.ones));
      end
    end
    if (done_m) begin
      if (q_m.size() == 0) begin
        check_val("unexpected_done_m", 32'(done_m), 32'd0);
      end else begin
        e_m = q_m.pop_front();
        check_val("word_m", 32'(word_m), 32'(e_m.word));
        check_val("ovf_m", 32'(ovf_m), 32'(e_m.ovf));
        check_val("loopback_m", 32'(popcount(word_m)), 32'(e_m.ones));
      end
    end
  end

  // One request: pulse start, measure start-edge-to-done latency, then
  // confirm done was a single-cycle pulse. With disturb set, start is pulsed
  // and count_in changed while FILL is running.
  task automatic run_req(input logic [4:0] n, input bit msb, input bit disturb);
    int k;
    bit seen;
    int ns;
    ns = (n > 5'd16) ? 16 : int'(n);
    if (msb) q_m.push_back(make_exp(n, 1'b1));
    else     q_l.push_back(make_exp(n, 1'b0));
    @(negedge clk);
    count_in = n;
    if (msb) start_m = 1'b1;
    else     start   = 1'b1;
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 64) begin
      @(posedge clk);
      #1;
      k++;
      start   = 1'b0;
      start_m = 1'b0;
      if (disturb && k == 3) begin
        start    = 1'b1;
        count_in = 5'd2;
      end
      seen = msb ? done_m : done;
    end
    if (!seen) check_val("done_timeout", 32'(seen), 32'd1);
    else       check_val(msb ? "latency_m" : "latency", 32'(k), 32'(ns + 2));
    @(posedge clk);
    #1;
    check_val("done_pulse", 32'(msb ? done_m : done), 32'd0);
    check_val("idle_after_done", 32'(msb ? busy_m : busy), 32'd0);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 64) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) check_val("b2b_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    start    = 1'b0;
    start_m  = 1'b0;
    count_in = 5'd0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_word", 32'(word_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state held through idle cycles.
    repeat (5) @(posedge clk);
    #1;
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_done", 32'(done), 32'd0);
    check_val("idle_ovf", 32'(ovf), 32'd0);
    check_val("idle_word", 32'(word_out), 32'h0000);
    check_val("idle_word_m", 32'(word_m), 32'h0000);

    // Basic request, then the result must hold through IDLE.
    run_req(5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("hold", 32'(word_out), 32'h001F);
    end

    // Boundaries: empty word, exactly full, saturation and ovf clearing.
    run_req(5'd0, 1'b0, 1'b0);
    run_req(5'd16, 1'b0, 1'b0);
    run_req(5'd23, 1'b0, 1'b0);
    @(negedge clk);
    check_val("ovf_held", 32'(ovf), 32'd1);
    run_req(5'd3, 1'b0, 1'b0);
    run_req(5'd3, 1'b1, 1'b0);
    run_req(5'd31, 1'b1, 1'b0);

    // start and count_in changes during FILL are ignored.
    run_req(5'd9, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_val("no_requeue", 32'(busy), 32'd0);
    check_val("disturb_word", 32'(word_out), 32'h01FF);

    // start held through DONE is re-accepted after one IDLE cycle.
    q_l.push_back(make_exp(5'd4, 1'b0));
    q_l.push_back(make_exp(5'd4, 1'b0));
    @(negedge clk);
    count_in = 5'd4;
    start    = 1'b1;
    wait_done(k);
    @(posedge clk);
    #1;
    check_val("b2b_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_val("b2b_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(k);
    repeat (2) @(posedge clk);

    // Reset mid-FILL: immediate clear and no done pulse afterwards.
    run_req(5'd20, 1'b0, 1'b0);
    @(negedge clk);
    count_in = 5'd12;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("midrst_word", 32'(word_out), 32'h0000);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("post_rst_busy", 32'(busy), 32'd0);

    // Loopback sweep over every count value.
    for (int n = 0; n < 32; n++) begin
      run_req(5'(n), 1'b0, 1'b0);
    end
    for (int n = 0; n < 32; n += 5) begin
      run_req(5'(n), 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    check_val("queue_empty", 32'(q_l.size() + q_m.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
